sformat_pad_align_stream: RTL and testbench

SFORMAT_PAD_ALIGN_STREAM -- requirements
Module: sformat_pad_align_stream

---
 rtl/sformat_pad_align_stream.sv | 200 ++++++++++++++++++++
 tb/tb_sformat_pad_align_stream.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sformat_pad_align_stream.sv
// sformat_pad_align_stream
// Formats one integer per request as a decimal ASCII field with a minimum
// width, space or zero padding and optional left justification, streamed out
// one character per handshake.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready only when idle)
//   in_value          integer to format (two's complement when in_signed)
//   in_width          minimum field width in characters
//   in_zero, in_left  zero-pad / left-justify flags
//   out_valid/ready   character handshake
//   out_char, out_last ASCII character, final character of the field
//   busy              request in progress
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CONV  | peeling one decimal digit per cycle, least significant first
// EMIT  | streaming pad, sign and digits
module sformat_pad_align_stream #(
   parameter int DATA_W  = 16,
   parameter int DIG_MAX = 5,
   parameter int WID_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_value,
   input  logic [WID_W-1:0]  in_width,
   input  logic              in_zero,
   input  logic              in_left,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_char,
   output logic              out_last,
   output logic              busy
);

   localparam int CNT_W = $clog2(DIG_MAX + 1);
   localparam int LW    = ((WID_W > CNT_W) ? WID_W : CNT_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [DATA_W-1:0]  r_mag;
   logic               r_neg;
   logic [WID_W-1:0]   r_width;
   logic               r_zero;
   logic               r_left;
   logic [3:0]         r_dig [DIG_MAX];
   logic [CNT_W-1:0]   r_dcnt;
   logic [CNT_W-1:0]   r_didx;
   logic [WID_W-1:0]   r_pad;
   logic               r_sign;

   logic               w_neg_in;
   logic [DATA_W-1:0]  w_quot;
   logic [3:0]         w_digit;
   logic               w_conv_done;
   logic [LW-1:0]      w_len;
   logic [LW-1:0]      w_wid_ext;
   logic [WID_W-1:0]   w_pad;
   logic [LW-1:0]      w_remain;
   logic [CNT_W-1:0]   w_didx_m1;
   logic [7:0]         w_dig_char;
   logic               w_fire;
   logic               w_take_pad;
   logic               w_take_sign;
   logic               w_take_dig;

   assign w_neg_in    = in_signed && in_value[DATA_W-1];
   assign w_quot      = r_mag / DATA_W'(10);
   assign w_digit     = 4'(r_mag % DATA_W'(10));
   assign w_conv_done = (w_quot == '0);

   // Field length once the digit being stored this cycle is counted.
   assign w_len       = LW'(r_dcnt) + LW'(1) + LW'(r_neg);
   assign w_wid_ext   = LW'(r_width);
   assign w_pad       = (w_wid_ext > w_len) ? WID_W'(w_wid_ext - w_len) : '0;

   assign w_remain    = LW'(r_pad) + LW'(r_sign) + LW'(r_didx);
   assign w_didx_m1   = r_didx - CNT_W'(1);
   assign w_dig_char  = {4'h3, r_dig[w_didx_m1]};
   assign w_fire      = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_char    = 8'h00;
      out_last    = 1'b0;
      w_take_pad  = 1'b0;
      w_take_sign = 1'b0;
      w_take_dig  = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_CONV;
         end
         S_CONV: begin
            if (w_conv_done) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = (w_remain == LW'(1));
            if (r_left) begin
               if (r_sign) begin
                  out_char = 8'h2D; w_take_sign = 1'b1;
               end else if (r_didx != '0) begin
                  out_char = w_dig_char; w_take_dig = 1'b1;
               end else begin
                  out_char = 8'h20; w_take_pad = 1'b1;
               end
            end else if (r_zero) begin
               if (r_sign) begin
                  out_char = 8'h2D; w_take_sign = 1'b1;
               end else if (r_pad != '0) begin
                  out_char = 8'h30; w_take_pad = 1'b1;
               end else begin
                  out_char = w_dig_char; w_take_dig = 1'b1;
               end
            end else begin
               if (r_pad != '0) begin
                  out_char = 8'h20; w_take_pad = 1'b1;
               end else if (r_sign) begin
                  out_char = 8'h2D; w_take_sign = 1'b1;
               end else begin
                  out_char = w_dig_char; w_take_dig = 1'b1;
               end
            end
            if (out_ready && out_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      busy = !in_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mag   <= '0;
         r_neg   <= 1'b0;
         r_width <= '0;
         r_zero  <= 1'b0;
         r_left  <= 1'b0;
         r_dcnt  <= '0;
         r_didx  <= '0;
         r_pad   <= '0;
         r_sign  <= 1'b0;
         for (int i = 0; i < DIG_MAX; i++) r_dig[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_neg   <= w_neg_in;
                  // Negating the most-negative value wraps back to itself,
                  // which read as unsigned is exactly its magnitude.
                  r_mag   <= w_neg_in ? (~in_value + DATA_W'(1)) : in_value;
                  r_width <= in_width;
                  r_zero  <= in_zero;
                  r_left  <= in_left;
                  r_dcnt  <= '0;
                  r_didx  <= '0;
                  r_pad   <= '0;
                  r_sign  <= 1'b0;
               end
            end
            S_CONV: begin
               if (r_dcnt < CNT_W'(DIG_MAX)) begin
                  r_dig[r_dcnt] <= w_digit;
                  r_dcnt        <= r_dcnt + CNT_W'(1);
               end
               r_mag <= w_quot;
               if (w_conv_done) begin
                  r_didx <= r_dcnt + CNT_W'(1);
                  r_pad  <= w_pad;
                  r_sign <= r_neg;
               end
            end
            S_EMIT: begin
               if (w_fire) begin
                  if (w_take_pad)  r_pad  <= r_pad - WID_W'(1);
                  if (w_take_sign) r_sign <= 1'b0;
                  if (w_take_dig)  r_didx <= w_didx_m1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sformat_pad_align_stream.sv
module tb_sformat_pad_align_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_value;
   logic [3:0]  in_width;
   logic        in_zero, in_left, in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_char;
   logic        out_last;
   logic        busy;

   sformat_pad_align_stream #(.DATA_W(16), .DIG_MAX(5), .WID_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .in_width(in_width), .in_zero(in_zero), .in_left(in_left),
      .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] ch;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   time  lat_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the stimulus

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Reference formatter: build the character list by decimal arithmetic.
   task automatic send(input logic [15:0] v, input int w, input bit z, input bit l, input bit s);
      longint     mag;
      bit         neg;
      logic [7:0] dg[$];
      logic [7:0] cq[$];
      int         d, len, p, n;
      time        t;
      neg = s && v[15];
      mag = neg ? (longint'(65536) - longint'(v)) : longint'(v);
      do begin
         dg.push_front(8'(48 + mag % 10));
         mag = mag / 10;
      end while (mag != 0);
      d   = dg.size();
      len = d + int'(neg);
      p   = (w > len) ? w - len : 0;
      if (l) begin
         if (neg) cq.push_back(8'h2D);
         foreach (dg[i]) cq.push_back(dg[i]);
         repeat (p) cq.push_back(8'h20);
      end else if (z) begin
         if (neg) cq.push_back(8'h2D);
         repeat (p) cq.push_back(8'h30);
         foreach (dg[i]) cq.push_back(dg[i]);
      end else begin
         repeat (p) cq.push_back(8'h20);
         if (neg) cq.push_back(8'h2D);
         foreach (dg[i]) cq.push_back(dg[i]);
      end

      n = 0;
      @(negedge clk);
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("send_wait_ready", 0, 1);
         return;
      end
      in_valid  = 1'b1;
      in_value  = v;
      in_width  = 4'(w);
      in_zero   = z;
      in_left   = l;
      in_signed = s;
      @(posedge clk);
      t = $time;
      foreach (cq[i]) exp_q.push_back({cq[i], (i == cq.size() - 1)});
      lat_q.push_back(t + time'(d) * 10 + 5);
      #1 in_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares every presented/accepted character with the queue.
   bit         m_first = 1'b1;
   bit         m_held  = 1'b0;
   bit         m_post_last = 1'b0;
   logic [7:0] m_held_ch;
   logic       m_held_last;
   exp_t       m_e;
   time        m_t;

   always @(negedge clk) begin
      if (rst) begin
         m_first     = 1'b1;
         m_held      = 1'b0;
         m_post_last = 1'b0;
      end else begin
         if (m_post_last) begin
            chk("ready_after_last", in_ready, 1);
            m_post_last = 1'b0;
         end
         if (m_held)
            chk("stall_stable", {out_valid, out_char, out_last}, {1'b1, m_held_ch, m_held_last});
         if (out_valid) begin
            if (m_first) begin
               if (lat_q.size() == 0) chk("latency_unexpected", 1, 0);
               else begin
                  m_t = lat_q.pop_front();
                  chk("first_valid_time", $time, m_t);
               end
               m_first = 1'b0;
            end
            if (out_ready) begin
               m_held = 1'b0;
               if (exp_q.size() == 0) chk("unexpected_char", out_char, 0);
               else begin
                  m_e = exp_q.pop_front();
                  chk("char", out_char, m_e.ch);
                  chk("last", out_last, m_e.last);
                  if (m_e.last) begin
                     m_first     = 1'b1;
                     m_post_last = 1'b1;
                  end
               end
            end else begin
               m_held      = 1'b1;
               m_held_ch   = out_char;
               m_held_last = out_last;
            end
         end else begin
            chk("char_zero_when_idle", out_char, 0);
         end
      end
   end

   task automatic wait_first_valid();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("wait_out_valid", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && in_ready) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_value = '0; in_width = '0;
      in_zero = 1'b0; in_left = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_char", out_char, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      ready_mode = 0;
      send(16'd5, 5, 0, 0, 0);
      send(16'd5, 5, 1, 0, 0);
      send(16'd5, 5, 1, 1, 0);
      send(16'hFFF9, 4, 1, 0, 1);
      send(16'hFFF9, 4, 0, 0, 1);
      send(16'h8000, 0, 0, 0, 1);
      send(16'd65535, 3, 0, 0, 0);
      send(16'd0, 0, 0, 0, 0);
      send(16'h8000, 15, 1, 0, 1);
      send(16'h8000, 15, 0, 1, 1);
      send(16'hFFFF, 6, 0, 1, 1);
      send(16'd42, 2, 1, 0, 0);
      drain();

      // Stall on the second character of "  -7" with a request pending.
      ready_mode = 2;
      out_ready  = 1'b1;
      send(16'hFFF9, 4, 0, 0, 1);
      wait_first_valid();
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1; in_value = 16'd123; in_width = 4'd0;
      in_zero = 1'b0; in_left = 1'b0; in_signed = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_char", {out_valid, out_char}, {1'b1, 8'h20});
         chk("emit_in_ready_low", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      ready_mode = 0;
      drain();

      // Reset in the middle of "00005".
      send(16'd5, 5, 1, 0, 0);
      wait_first_valid();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_char", out_char, 0);
      exp_q.delete();
      lat_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      send(16'd123, 6, 1, 0, 0);
      drain();

      ready_mode = 1;
      for (int k = 0; k < 60; k++) begin
         logic [15:0] v;
         case ($urandom_range(0, 5))
            0:       v = 16'h8000;
            1:       v = 16'd0;
            2:       v = 16'hFFFF;
            default: v = 16'($urandom);
         endcase
         send(v, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
